dds_ddc_center_hls_deadlock_monitor_v2: RTL

//  Parametrised deadlock monitor for one HLS instance of the dds_ddc_center datapath. Watches N_AXIS
//  AXI-stream stall flags and N_INST sub-instance idle/block pairs, and debounces a stall condition

---
 rtl/dds_ddc_center_dlm_pkg.sv | 16 +
 rtl/dds_ddc_center_dlm_persist.sv | 30 +++
 rtl/dds_ddc_center_hls_deadlock_monitor_v2.sv | 102 ++++++++++
 3 files changed

// File: rtl/dds_ddc_center_dlm_pkg.sv
// Shared types and helpers for the dds_ddc_center HLS deadlock monitor.
// Holds the monitor FSM state encoding and the persistence-counter width rule.
package dds_ddc_center_dlm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } dlm_state_e;

    // Counter must be able to hold the value HOLD_CYCLES itself (saturation point).
    function automatic int cnt_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/dds_ddc_center_dlm_persist.sv
// Saturating persistence counter: counts consecutive cycles with 'active' high and
// raises 'hit' on the cycle whose sample completes 'threshold' consecutive hits.
module dds_ddc_center_dlm_persist #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         active,
    input  logic         clear,
    input  logic [W-1:0] threshold,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || !active) begin
            cnt <= '0;
        end else if (cnt != threshold) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of already-stalled cycles, so the current stalled
    // cycle is the threshold-th one when cnt has reached threshold-1.
    assign hit = active && (cnt >= threshold - 1'b1);

endmodule

// File: rtl/dds_ddc_center_hls_deadlock_monitor_v2.sv
// Deadlock monitor for one dds_ddc_center HLS instance: debounces the combined stall
// condition, flags deadlock, snapshots the first cause and counts episodes.
module dds_ddc_center_hls_deadlock_monitor_v2
    import dds_ddc_center_dlm_pkg::*;
#(
    parameter int N_AXIS      = 4,
    parameter int N_INST      = 1,
    parameter int HOLD_CYCLES = 16,
    parameter int STICKY      = 0,
    parameter int EPI_W       = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_AXIS-1:0]        axis_block_sigs,
    input  logic [N_INST-1:0]        inst_idle_sigs,
    input  logic [N_INST-1:0]        inst_block_sigs,
    input  logic                     clear,
    output logic                     block,
    output logic [N_AXIS+N_INST-1:0] first_cause,
    output logic [EPI_W-1:0]         episodes
);

    localparam int              CW      = cnt_width(HOLD_CYCLES);
    localparam int              SW      = N_AXIS + N_INST;
    localparam logic [CW-1:0]   HOLD_TH = CW'(HOLD_CYCLES);

    dlm_state_e    state, state_nxt;
    logic [SW-1:0] stall_vec;
    logic [SW-1:0] cand;
    logic          stall;
    logic          hit;
    logic          enter_blk;

    // An idle sub-instance is never treated as blocked.
    assign stall_vec = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
    assign stall     = |stall_vec;

    dds_ddc_center_dlm_persist #(
        .W (CW)
    ) u_persist (
        .clock     (clock),
        .reset_n   (reset_n),
        .active    (stall),
        .clear     (clear),
        .threshold (HOLD_TH),
        .hit       (hit)
    );

    always_comb begin
        state_nxt = state;
        enter_blk = 1'b0;
        case (state)
            IDLE: begin
                // hit can only fire here when HOLD_CYCLES is 1
                if (hit) begin
                    state_nxt = BLOCKED;
                    enter_blk = 1'b1;
                end else if (stall) begin
                    state_nxt = SUSPECT;
                end
            end
            SUSPECT: begin
                if (!stall) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    state_nxt = BLOCKED;
                    enter_blk = 1'b1;
                end
            end
            BLOCKED: begin
                if (STICKY == 0 && !stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            enter_blk = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            block       <= 1'b0;
            cand        <= '0;
            first_cause <= '0;
            episodes    <= '0;
        end else begin
            state <= state_nxt;
            block <= (state_nxt == BLOCKED);
            if (!clear && state == IDLE && stall) cand <= stall_vec;
            if (clear) begin
                first_cause <= '0;
            end else if (enter_blk) begin
                // Direct IDLE->BLOCKED has no stored candidate yet; use the live vector.
                first_cause <= (state == IDLE) ? stall_vec : cand;
            end
            if (enter_blk && episodes != {EPI_W{1'b1}}) episodes <= episodes + 1'b1;
        end
    end

endmodule
